// File: rtl/controle_irrigacao.sv
// Tank-fed irrigation controller: debounces the H/M/L level sensors and sequences
// the inlet valve (fill) and outlet pump (irrigate), with a latched operator-cleared fault.
module controle_irrigacao #(
  parameter int DEB_CYCLES   = 4,
  parameter int IRR_TIME     = 16,
  parameter int FILL_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       H,
  input  logic       M,
  input  logic       L,
  input  logic       Seco,
  input  logic       Ack,
  output logic       Ve,
  output logic       Vs,
  output logic       Erro,
  output logic       Alarme,
  output logic [1:0] Estado,
  output logic [7:0] Ciclos
);

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] FILL     = 2'b01;
  localparam logic [1:0] IRRIGATE = 2'b10;
  localparam logic [1:0] FAULT    = 2'b11;

  localparam int CW   = $clog2(DEB_CYCLES + 1);
  localparam int TMAX = (IRR_TIME > FILL_TIMEOUT) ? IRR_TIME : FILL_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] CNT_SAT   = CW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] FILL_LAST = TW'(FILL_TIMEOUT - 1);
  localparam logic [TW-1:0] IRR_LAST  = TW'(IRR_TIME - 1);

  logic [2:0]    sample;
  logic [2:0]    prev;
  logic [2:0]    lvl;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cntNext;
  logic [1:0]    state;
  logic [1:0]    stateNext;
  logic [TW-1:0] tmr;
  logic [7:0]    ciclos;
  logic          lvlVazio;
  logic          lvlBaixo;
  logic          lvlMedio;
  logic          lvlCheio;
  logic          lvlValid;
  logic          irrDone;

  assign sample = {H, M, L};

  // cnt holds (identical consecutive samples - 1); the level is accepted once it reaches DEB_CYCLES-1
  always_comb begin
    cntNext = '0;
    if (sample == prev) begin
      cntNext = (cnt == CNT_SAT) ? CNT_SAT : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 3'b000;
      cnt  <= '0;
      lvl  <= 3'b000;
    end else begin
      prev <= sample;
      cnt  <= cntNext;
      if (cntNext == CNT_SAT) begin
        lvl <= sample;
      end
    end
  end

  assign lvlVazio = (lvl == 3'b000);
  assign lvlBaixo = (lvl == 3'b001);
  assign lvlMedio = (lvl == 3'b011);
  assign lvlCheio = (lvl == 3'b111);
  assign lvlValid = lvlVazio | lvlBaixo | lvlMedio | lvlCheio;
  assign irrDone  = (state == IRRIGATE) && (tmr == IRR_LAST);

  // An inconsistent sensor code overrides every other transition
  always_comb begin
    stateNext = state;
    if (!lvlValid) begin
      stateNext = FAULT;
    end else begin
      case (state)
        IDLE: begin
          if (lvlVazio || lvlBaixo) begin
            stateNext = FILL;
          end else if (Seco) begin
            stateNext = IRRIGATE;
          end
        end
        FILL: begin
          if (lvlCheio) begin
            stateNext = IDLE;
          end else if (tmr == FILL_LAST) begin
            stateNext = FAULT;
          end
        end
        IRRIGATE: begin
          if (lvlVazio || lvlBaixo) begin
            stateNext = FILL;
          end else if (irrDone) begin
            stateNext = IDLE;
          end
        end
        default: begin
          if (Ack) begin
            stateNext = IDLE;
          end
        end
      endcase
    end
  end

  // One shared timer serves FILL and IRRIGATE; it restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      tmr    <= '0;
      ciclos <= 8'd0;
    end else begin
      state <= stateNext;
      if ((stateNext != state) || (state == IDLE) || (state == FAULT)) begin
        tmr <= '0;
      end else begin
        tmr <= tmr + 1'b1;
      end
      if (irrDone && (stateNext == IDLE)) begin
        ciclos <= ciclos + 8'd1;
      end
    end
  end

  assign Ve     = (state == FILL);
  assign Vs     = (state == IRRIGATE);
  assign Erro   = (state == FAULT);
  assign Alarme = (state == FAULT) || lvlVazio;
  assign Estado = state;
  assign Ciclos = ciclos;

endmodule

// File: tb/tb_controle_irrigacao.sv
// Bench for controle_irrigacao: directed scenarios plus randomized sensor traffic,
// every cycle compared against a cycle-count reference model of the controller rules.
module tb_controle_irrigacao;

  localparam int DEB_CYCLES   = 4;
  localparam int IRR_TIME     = 16;
  localparam int FILL_TIMEOUT = 64;

  logic       clk;
  logic       rst_n;
  logic       H, M, L, Seco, Ack;
  logic       Ve, Vs, Erro, Alarme;
  logic [1:0] Estado;
  logic [7:0] Ciclos;

  int errors = 0;
  int checks = 0;

  int mState, mLvl, mLast, mRun, mElapsed, mCiclos;

  controle_irrigacao #(
    .DEB_CYCLES  (DEB_CYCLES),
    .IRR_TIME    (IRR_TIME),
    .FILL_TIMEOUT(FILL_TIMEOUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .H     (H),
    .M     (M),
    .L     (L),
    .Seco  (Seco),
    .Ack   (Ack),
    .Ve    (Ve),
    .Vs    (Vs),
    .Erro  (Erro),
    .Alarme(Alarme),
    .Estado(Estado),
    .Ciclos(Ciclos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit levelValid(int lv);
    return (lv == 0) || (lv == 1) || (lv == 3) || (lv == 7);
  endfunction

  task automatic modelReset();
    mState   = 0;
    mLvl     = 0;
    mLast    = 0;
    mRun     = 1;
    mElapsed = 0;
    mCiclos  = 0;
  endtask

  // Decision uses the level accepted before this edge; then the new sample is folded in
  task automatic modelStep(int s, bit seco, bit ack);
    int nxt;
    nxt = mState;
    mElapsed++;
    if (!levelValid(mLvl)) begin
      nxt = 3;
    end else begin
      case (mState)
        0: if (mLvl <= 1) nxt = 1; else if (seco) nxt = 2;
        1: if (mLvl == 7) nxt = 0; else if (mElapsed >= FILL_TIMEOUT) nxt = 3;
        2: begin
          if (mLvl <= 1) nxt = 1;
          else if (mElapsed >= IRR_TIME) begin
            nxt = 0;
            mCiclos = (mCiclos + 1) % 256;
          end
        end
        default: if (ack) nxt = 0;
      endcase
    end
    if (nxt != mState) mElapsed = 0;
    mState = nxt;
    if (s == mLast) mRun++;
    else begin
      mRun  = 1;
      mLast = s;
    end
    if (mRun >= DEB_CYCLES) mLvl = s;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("Estado", 8'(Estado), 8'(mState));
    checkOutput("Ve", 8'(Ve), 8'(mState == 1));
    checkOutput("Vs", 8'(Vs), 8'(mState == 2));
    checkOutput("Erro", 8'(Erro), 8'(mState == 3));
    checkOutput("Alarme", 8'(Alarme), 8'((mState == 3) || (mLvl == 0)));
    checkOutput("Ciclos", Ciclos, 8'(mCiclos));
  endtask

  task automatic applyStimulus(input logic [2:0] hml, input logic seco, input logic ack, input int n);
    {H, M, L} = hml;
    Seco = seco;
    Ack  = ack;
    repeat (n) begin
      @(posedge clk);
      modelStep(int'(hml), seco, ack);
      #1;
      checkAll();
    end
  endtask

  initial begin
    logic [2:0] pick [8];
    pick = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b111, 3'b011, 3'b101, 3'b010};

    rst_n = 1'b0;
    {H, M, L} = 3'b000;
    Seco = 1'b0;
    Ack  = 1'b0;
    modelReset();
    #12;
    checkOutput("rstVe", 8'(Ve), 8'd0);
    checkOutput("rstVs", 8'(Vs), 8'd0);
    checkOutput("rstErro", 8'(Erro), 8'd0);
    checkOutput("rstAlarme", 8'(Alarme), 8'd1);
    checkOutput("rstEstado", 8'(Estado), 8'd0);
    checkOutput("rstCiclos", Ciclos, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Empty tank after reset starts filling
    applyStimulus(3'b000, 1'b0, 1'b0, 6);
    checkOutput("fillEntry", 8'(Estado), 8'd1);
    checkOutput("fillVe", 8'(Ve), 8'd1);

    // Filling up through the levels, then a short glitch while full
    applyStimulus(3'b001, 1'b0, 1'b0, 6);
    applyStimulus(3'b011, 1'b0, 1'b0, 6);
    applyStimulus(3'b111, 1'b0, 1'b0, 6);
    checkOutput("fullIdle", 8'(Estado), 8'd0);
    applyStimulus(3'b011, 1'b0, 1'b0, 2);
    applyStimulus(3'b111, 1'b0, 1'b0, 4);
    checkOutput("glitchIdle", 8'(Estado), 8'd0);
    checkOutput("glitchAlarme", 8'(Alarme), 8'd0);

    // One full irrigation cycle
    applyStimulus(3'b111, 1'b1, 1'b0, 1);
    applyStimulus(3'b111, 1'b0, 1'b0, 18);
    checkOutput("irrCount", Ciclos, 8'd1);

    // Invalid code during irrigation, Ack ignored while still invalid
    applyStimulus(3'b111, 1'b1, 1'b0, 1);
    applyStimulus(3'b101, 1'b0, 1'b0, 5);
    checkOutput("invFault", 8'(Estado), 8'd3);
    applyStimulus(3'b101, 1'b0, 1'b1, 3);
    checkOutput("ackIgnored", 8'(Estado), 8'd3);
    applyStimulus(3'b111, 1'b0, 1'b0, 5);
    applyStimulus(3'b111, 1'b0, 1'b1, 1);
    checkOutput("ackExit", 8'(Estado), 8'd0);

    // Fill that never reaches full times out
    applyStimulus(3'b001, 1'b0, 1'b0, 75);
    checkOutput("timeoutFault", 8'(Estado), 8'd3);
    checkOutput("timeoutVe", 8'(Ve), 8'd0);
    applyStimulus(3'b111, 1'b0, 1'b0, 5);
    applyStimulus(3'b111, 1'b0, 1'b1, 1);

    // Level drop aborts irrigation, then reset lands mid-fill
    applyStimulus(3'b111, 1'b1, 1'b0, 1);
    applyStimulus(3'b111, 1'b0, 1'b0, 7);
    applyStimulus(3'b001, 1'b0, 1'b0, 6);
    checkOutput("abortFill", 8'(Estado), 8'd1);
    checkOutput("abortCiclos", Ciclos, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncVe", 8'(Ve), 8'd0);
    checkOutput("asyncVs", 8'(Vs), 8'd0);
    checkOutput("asyncEstado", 8'(Estado), 8'd0);
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst2Ciclos", Ciclos, 8'd0);
    checkOutput("rst2Alarme", 8'(Alarme), 8'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized sensor traffic with random hold lengths
    for (int i = 0; i < 70; i++) begin
      applyStimulus(pick[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) == 0), $urandom_range(1, 8));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
